// File: rtl/stream_router_pkg.sv
// rtl/stream_router_pkg.sv - shared state type and id range helper for the id-tagged stream router
package stream_router_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_DROP = 2'd2
   } router_state_t;

   function automatic logic id_in_range(input int unsigned id, input int unsigned count);
      return id < count;
   endfunction

endpackage

// File: rtl/stream_router_w_id_if.sv
// rtl/stream_router_w_id_if.sv - input stream, per-port output streams and drop count of the router
interface stream_router_w_id_if #(
   parameter int unsigned T_DATA_WIDTH   = 4,
   parameter int unsigned T_QOS__WIDTH   = 2,
   parameter int unsigned STREAM_COUNT   = 3,
   parameter int unsigned T_ID___WIDTH   = $clog2(STREAM_COUNT),
   parameter int unsigned DROP_CNT_WIDTH = 8
);

   logic [T_DATA_WIDTH-1:0]                    s_data_in;
   logic [T_QOS__WIDTH-1:0]                    s_qos_in;
   logic [T_ID___WIDTH-1:0]                    s_id_in;
   logic                                       s_last_in;
   logic                                       s_valid_in;
   logic                                       s_ready_out;

   logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0]  m_data_out;
   logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0]  m_qos_out;
   logic [STREAM_COUNT-1:0]                    m_last_out;
   logic [STREAM_COUNT-1:0]                    m_valid_out;
   logic [STREAM_COUNT-1:0]                    m_ready_in;

   logic [DROP_CNT_WIDTH-1:0]                  drop_count_out;

   modport master (
      output s_data_in, s_qos_in, s_id_in, s_last_in, s_valid_in,
      input  s_ready_out,
      input  m_data_out, m_qos_out, m_last_out, m_valid_out,
      output m_ready_in,
      input  drop_count_out
   );

   modport slave (
      input  s_data_in, s_qos_in, s_id_in, s_last_in, s_valid_in,
      output s_ready_out,
      output m_data_out, m_qos_out, m_last_out, m_valid_out,
      input  m_ready_in,
      output drop_count_out
   );

endinterface

// File: rtl/stream_out_slice.sv
// rtl/stream_out_slice.sv - one-entry output register with load/drain handshake and per-port decode
module stream_out_slice #(
   parameter int unsigned DATA_WIDTH   = 4,
   parameter int unsigned QOS_WIDTH    = 2,
   parameter int unsigned ID_WIDTH     = 2,
   parameter int unsigned STREAM_COUNT = 3
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    load,
   input  logic [DATA_WIDTH-1:0]                   load_data,
   input  logic [QOS_WIDTH-1:0]                    load_qos,
   input  logic                                    load_last,
   input  logic [ID_WIDTH-1:0]                     load_dest,
   input  logic [STREAM_COUNT-1:0]                 port_ready,
   output logic                                    slot_free,
   output logic [STREAM_COUNT-1:0]                 port_valid,
   output logic [STREAM_COUNT-1:0][DATA_WIDTH-1:0] port_data,
   output logic [STREAM_COUNT-1:0][QOS_WIDTH-1:0]  port_qos,
   output logic [STREAM_COUNT-1:0]                 port_last
);

   logic                  buf_valid;
   logic [DATA_WIDTH-1:0] buf_data;
   logic [QOS_WIDTH-1:0]  buf_qos;
   logic                  buf_last;
   logic [ID_WIDTH-1:0]   buf_dest;
   logic                  dest_ready;

   // Only the destination port's ready matters; the others are ignored.
   always_comb begin
      dest_ready = 1'b0;
      for (int i = 0; i < STREAM_COUNT; i++) begin
         if (buf_dest == ID_WIDTH'(i)) begin
            dest_ready = port_ready[i];
         end
      end
   end

   assign slot_free = !buf_valid || dest_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_valid <= 1'b0;
         buf_data  <= '0;
         buf_qos   <= '0;
         buf_last  <= 1'b0;
         buf_dest  <= '0;
      end else if (load) begin
         buf_valid <= 1'b1;
         buf_data  <= load_data;
         buf_qos   <= load_qos;
         buf_last  <= load_last;
         buf_dest  <= load_dest;
      end else if (buf_valid && dest_ready) begin
         buf_valid <= 1'b0;
      end
   end

   always_comb begin
      port_valid = '0;
      port_data  = '0;
      port_qos   = '0;
      port_last  = '0;
      for (int i = 0; i < STREAM_COUNT; i++) begin
         if (buf_dest == ID_WIDTH'(i)) begin
            port_valid[i] = buf_valid;
            port_data[i]  = buf_data;
            port_qos[i]   = buf_qos;
            port_last[i]  = buf_last;
         end
      end
   end

endmodule

// File: rtl/stream_router_w_id.sv
// rtl/stream_router_w_id.sv - routes whole tagged packets to output port id; drops and counts bad ids
module stream_router_w_id
   import stream_router_pkg::*;
#(
   parameter int unsigned T_DATA_WIDTH   = 4,
   parameter int unsigned T_QOS__WIDTH   = 2,
   parameter int unsigned STREAM_COUNT   = 3,
   parameter int unsigned T_ID___WIDTH   = $clog2(STREAM_COUNT),
   parameter int unsigned DROP_CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   stream_router_w_id_if.slave  bus
);

   router_state_t             state_q, state_d;
   logic [T_ID___WIDTH-1:0]   dest_q;
   logic [T_QOS__WIDTH-1:0]   qos_q;
   logic [DROP_CNT_WIDTH-1:0] drop_q;

   logic                      slot_free;
   logic                      s_ready;
   logic                      accept;
   logic                      id_ok;
   logic                      latch_ctx;
   logic                      load;
   logic                      drop_inc;
   logic [T_ID___WIDTH-1:0]   load_dest;
   logic [T_QOS__WIDTH-1:0]   load_qos;

   assign id_ok  = id_in_range(32'(bus.s_id_in), STREAM_COUNT);
   assign accept = bus.s_valid_in && s_ready;

   always_comb begin
      state_d   = state_q;
      s_ready   = (state_q == ST_DROP) ? 1'b1 : slot_free;
      load      = 1'b0;
      drop_inc  = 1'b0;
      latch_ctx = 1'b0;
      load_dest = dest_q;
      load_qos  = qos_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (id_ok) begin
                  // First beat routes with its own tag, ahead of the latch update.
                  load      = 1'b1;
                  latch_ctx = 1'b1;
                  load_dest = bus.s_id_in;
                  load_qos  = bus.s_qos_in;
                  if (!bus.s_last_in) begin
                     state_d = ST_FWD;
                  end
               end else begin
                  drop_inc = 1'b1;
                  if (!bus.s_last_in) begin
                     state_d = ST_DROP;
                  end
               end
            end
         end
         ST_FWD: begin
            if (accept) begin
               load = 1'b1;
               if (bus.s_last_in) begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DROP: begin
            if (accept && bus.s_last_in) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         dest_q  <= '0;
         qos_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         if (latch_ctx) begin
            dest_q <= bus.s_id_in;
            qos_q  <= bus.s_qos_in;
         end
         if (drop_inc && (drop_q != '1)) begin
            drop_q <= drop_q + DROP_CNT_WIDTH'(1);
         end
      end
   end

   assign bus.s_ready_out    = s_ready;
   assign bus.drop_count_out = drop_q;

   stream_out_slice #(
      .DATA_WIDTH   (T_DATA_WIDTH),
      .QOS_WIDTH    (T_QOS__WIDTH),
      .ID_WIDTH     (T_ID___WIDTH),
      .STREAM_COUNT (STREAM_COUNT)
   ) u_slice (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_data  (bus.s_data_in),
      .load_qos   (load_qos),
      .load_last  (bus.s_last_in),
      .load_dest  (load_dest),
      .port_ready (bus.m_ready_in),
      .slot_free  (slot_free),
      .port_valid (bus.m_valid_out),
      .port_data  (bus.m_data_out),
      .port_qos   (bus.m_qos_out),
      .port_last  (bus.m_last_out)
   );

endmodule

// File: doc/stream_router_w_id.md
# stream_router_w_id

Single-input, multi-output stream demultiplexer: the fan-out counterpart of the QoS stream arbiter. It accepts one tagged packet stream carrying data, QoS and destination id. Each packet is routed whole to output port `id`, with destination and QoS locked at the first beat. Packets with an out-of-range id are discarded and counted. Output is registered through a one-entry slice, giving full throughput and no combinational valid path.

## Interface
- `T_DATA_WIDTH`, default 4: data beat width
- `T_QOS__WIDTH`, default 2: QoS tag width
- `STREAM_COUNT`, default 3: number of output ports, ≥2
- `T_ID___WIDTH`, default `$clog2(STREAM_COUNT)`: id width
- `DROP_CNT_WIDTH`, default 8: drop counter width
- `clk`  in  1  clock; one clock domain
- `rst`  in  1  reset; synchronous, active-high
- `s_data_in`  in  T_DATA_WIDTH  input beat data
- `s_qos_in`  in  T_QOS__WIDTH  packet QoS; sampled at first beat only
- `s_id_in`  in  T_ID___WIDTH  destination port; sampled at first beat only
- `s_last_in`  in  1  last beat of packet
- `s_valid_in`  in  1  input beat valid
- `s_ready_out`  out  1  input beat accepted when valid&&ready
- `m_data_out`  out  [STREAM_COUNT] × T_DATA_WIDTH  per-port data
- `m_qos_out`  out  [STREAM_COUNT] × T_QOS__WIDTH  per-port QoS, latched value
- `m_last_out`  out  STREAM_COUNT  per-port last
- `m_valid_out`  out  STREAM_COUNT  per-port valid; at most one bit set
- `m_ready_in`  in  STREAM_COUNT  per-port ready
- `drop_count_out`  out  DROP_CNT_WIDTH  dropped-packet count, saturating

## Operation
- FSM states: ST_IDLE (expecting first beat), ST_FWD (mid-packet, forwarding), ST_DROP (mid-packet, discarding).
- Slice: `buf_valid`, `buf_data`, `buf_last`, `buf_qos`, `buf_dest`.
- `slot_free = !buf_valid || m_ready_in[buf_dest]`.
- `s_ready_out` = 1 in ST_DROP; otherwise `slot_free`.
- ST_IDLE, beat accepted:
  - Valid id (`s_id_in < STREAM_COUNT`): latch `dest = s_id_in` and `qos = s_qos_in`, load beat into the slice. If last, stay ST_IDLE; else go to ST_FWD.
  - Invalid id: do not load the slice; increment `drop_count_out` (saturate at all-ones). If last, stay ST_IDLE; else go to ST_DROP.
- ST_FWD, beat accepted: load into slice with latched dest/qos, ignoring `s_id_in`/`s_qos_in`. On last → ST_IDLE.
- ST_DROP, beat accepted: discard. On last → ST_IDLE.
- Slice update each cycle:
  - If a beat is loaded → `buf_valid=1`.
  - Else if `buf_valid && m_ready_in[buf_dest]` → `buf_valid=0`.
- Port i outputs:
  - `m_valid_out[i] = buf_valid && buf_dest==i`.
  - `m_data_out[i]`, `m_qos_out[i]`, `m_last_out[i]` carry buffer contents when `buf_dest==i`, else 0.
- Ready of non-destination ports is ignored. A stalled destination stalls the input (head-of-line); no reordering between packets.

## Timing
- Reset (synchronous, dominates all other events):
  - Effects: state=ST_IDLE, `buf_valid=0`, drop count 0, latched dest/qos 0.
  - Outputs: all `m_valid_out`/data/qos/last 0. `s_ready_out` = 1 in the cycle after reset (slot free).
- Mid-packet reset discards the buffered beat and packet context. The next accepted beat is treated as a first beat.
- Latency: accepted beat appears on `m_valid_out` the next cycle.
- Throughput: 1 beat/cycle when destination ready held high.
- Back-to-back packets, zero bubble: the last beat of packet A and the first beat of packet B to a different port are accepted on consecutive cycles. The slice drains A's last beat in the same cycle it loads B's first beat.
- Dropped packets consume one input beat per cycle, independent of `m_ready_in`. A drop starting in ST_IDLE still waits for `slot_free`.
- `s_valid_in` low mid-packet: state holds, slice drains normally.
- Single-beat packet (first and last in one beat): remains ST_IDLE.

## Structure
- Package `stream_router_pkg`: `router_state_t` enum (ST_IDLE, ST_FWD, ST_DROP, 2-bit), and function `id_in_range(id, count)`.
- Sub-module `stream_out_slice`: the one-entry buffer with load/drain handshake and per-port valid/data decode, parameterised on widths and STREAM_COUNT. The top holds the FSM, dest/qos latch and drop counter.

## Test plan
- 3-beat packet, id=2, qos=3, `m_ready_in`=3'b111 → port 2 valid on cycles 1–3 with qos=3 on every beat, last on the 3rd; ports 0/1 valid stay 0.
- Packet id=1 then immediate packet id=0, all ready → 5 consecutive `s_ready_out`=1 cycles, no bubble; port switches on the cycle after A's last.
- `s_id_in` changes 1→0 and `s_qos_in` changes 2→1 on beat 2 of a packet to port 1 → beat 2 still on port 1 with qos=2.
- 4-beat packet id=3 (STREAM_COUNT=3) → all beats accepted, no `m_valid_out`, `drop_count_out` 0→1; with DROP_CNT_WIDTH=2 and 5 bad packets the count reads 3.
- Port 0 `m_ready_in`=0 for 4 cycles mid-packet → `s_ready_out` low after the slice fills, data held stable; resumes with no loss or duplication.
- `rst` asserted mid-packet with slice full → next cycle all outputs 0 and `s_ready_out`=1; a subsequent beat with id=1 routes to port 1.
